// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, PC/HI/LO/InPort/MDR/Y/Z, bus mux and ALU.
// Optional macro MUL_DIV_EN builds the signed multiplier and divider.
module data_path #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             Read,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic R0out,  input logic R1out,  input logic R2out,  input logic R3out,
    input  logic R4out,  input logic R5out,  input logic R6out,  input logic R7out,
    input  logic R8out,  input logic R9out,  input logic R10out, input logic R11out,
    input  logic R12out, input logic R13out, input logic R14out, input logic R15out,
    input  logic HIOut,  input logic LOout,  input logic Zhighout, input logic Zlowout,
    input  logic PCout,  input logic MDRout, input logic InPortout, input logic Yout,
    input  logic R0in,   input logic R1in,   input logic R2in,   input logic R3in,
    input  logic R4in,   input logic R5in,   input logic R6in,   input logic R7in,
    input  logic R8in,   input logic R9in,   input logic R10in,  input logic R11in,
    input  logic R12in,  input logic R13in,  input logic R14in,  input logic R15in,
    input  logic HIin,   input logic LOin,   input logic ZHighin, input logic Zlowin,
    input  logic InPC,   input logic MDRin,  input logic InPortin, input logic Yin,
    output logic [WIDTH-1:0] BusOut,
    output logic [WIDTH-1:0] mdrData,
    output logic [WIDTH-1:0] BusMuxInR0,  output logic [WIDTH-1:0] BusMuxInR1,
    output logic [WIDTH-1:0] BusMuxInR2,  output logic [WIDTH-1:0] BusMuxInR3,
    output logic [WIDTH-1:0] BusMuxInR4,  output logic [WIDTH-1:0] BusMuxInR5,
    output logic [WIDTH-1:0] BusMuxInR6,  output logic [WIDTH-1:0] BusMuxInR7,
    output logic [WIDTH-1:0] BusMuxInR8,  output logic [WIDTH-1:0] BusMuxInR9,
    output logic [WIDTH-1:0] BusMuxInR10, output logic [WIDTH-1:0] BusMuxInR11,
    output logic [WIDTH-1:0] BusMuxInR12, output logic [WIDTH-1:0] BusMuxInR13,
    output logic [WIDTH-1:0] BusMuxInR14, output logic [WIDTH-1:0] BusMuxInR15,
    output logic [WIDTH-1:0] BusMuxInZhigh,
    output logic [WIDTH-1:0] BusMuxInZlow,
    output logic [WIDTH-1:0] BusMuxInPCout,
    output logic [WIDTH-1:0] BusMuxInInPortout,
    output logic [WIDTH-1:0] BusMuxInYout,
    output logic [WIDTH-1:0] BusMuxInHI,
    output logic [WIDTH-1:0] BusMuxInLO
);

    localparam int unsigned NGPR = 16;
    localparam int unsigned NSRC = 24;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;
    localparam logic [4:0] OP_NEG  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12;

    logic [WIDTH-1:0]   gpr [NGPR];
    logic [WIDTH-1:0]   hi, lo, pc, mdr, inport, y;
    logic [2*WIDTH-1:0] z;
    logic [WIDTH-1:0]   src [NSRC];
    logic [NSRC-1:0]    out_sel;
    logic [NGPR-1:0]    gpr_in;
    logic [WIDTH-1:0]   bus_c;
    logic [2*WIDTH-1:0] alu_c;

    assign out_sel = {Yout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIOut,
                      R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                      R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign gpr_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                      R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // Bus sources in priority order (index 0 highest)
    always_comb begin
        for (int i = 0; i < NGPR; i++) src[i] = gpr[i];
        src[16] = hi;
        src[17] = lo;
        src[18] = z[2*WIDTH-1:WIDTH];
        src[19] = z[WIDTH-1:0];
        src[20] = pc;
        src[21] = mdr;
        src[22] = inport;
        src[23] = y;
    end

    // Descending scan so the lowest-indexed asserted strobe is the last write
    always_comb begin
        bus_c = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (out_sel[i]) bus_c = src[i];
        end
    end

    // ALU: A = Y, B = bus
    logic [4:0]         shamt;
    logic [2*WIDTH-1:0] rot_r, rot_l;
    logic [WIDTH-1:0]   sra;
    assign shamt = bus_c[4:0];
    assign rot_r = {y, y} >> shamt;
    assign rot_l = {y, y} << shamt;
    assign sra   = WIDTH'($signed(y) >>> shamt);

`ifdef MUL_DIV_EN
    logic signed [2*WIDTH-1:0] mul_full;
    logic signed [WIDTH-1:0]   quo, rem;
    assign mul_full = $signed({{WIDTH{y[WIDTH-1]}}, y}) * $signed({{WIDTH{bus_c[WIDTH-1]}}, bus_c});
    assign quo      = (bus_c == '0) ? '1 : $signed(y) / $signed(bus_c);
    assign rem      = (bus_c == '0) ? $signed(y) : $signed(y) % $signed(bus_c);
`endif

    always_comb begin
        alu_c = {{WIDTH{1'b0}}, bus_c};
        case (op)
            OP_ADD:  alu_c = {{WIDTH{1'b0}}, WIDTH'(y + bus_c)};
            OP_SUB:  alu_c = {{WIDTH{1'b0}}, WIDTH'(y - bus_c)};
            OP_AND:  alu_c = {{WIDTH{1'b0}}, y & bus_c};
            OP_OR:   alu_c = {{WIDTH{1'b0}}, y | bus_c};
            OP_SHR:  alu_c = {{WIDTH{1'b0}}, WIDTH'(y >> shamt)};
            OP_SHRA: alu_c = {{WIDTH{1'b0}}, sra};
            OP_SHL:  alu_c = {{WIDTH{1'b0}}, WIDTH'(y << shamt)};
            OP_ROR:  alu_c = {{WIDTH{1'b0}}, rot_r[WIDTH-1:0]};
            OP_ROL:  alu_c = {{WIDTH{1'b0}}, rot_l[2*WIDTH-1:WIDTH]};
            OP_NOT:  alu_c = {{WIDTH{1'b0}}, ~bus_c};
            OP_NEG:  alu_c = {{WIDTH{1'b0}}, WIDTH'(-bus_c)};
`ifdef MUL_DIV_EN
            OP_MUL:  alu_c = mul_full;
            OP_DIV:  alu_c = {rem, quo};
`else
            OP_MUL:  alu_c = '0;
            OP_DIV:  alu_c = '0;
`endif
            default: alu_c = {{WIDTH{1'b0}}, bus_c};
        endcase
    end

    // Register file and special registers
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NGPR; i++) gpr[i] <= '0;
            hi     <= '0;
            lo     <= '0;
            pc     <= '0;
            mdr    <= '0;
            inport <= '0;
            y      <= '0;
            z      <= '0;
        end else begin
            for (int i = 0; i < NGPR; i++) begin
                if (gpr_in[i]) gpr[i] <= bus_c;
            end
            if (HIin)     hi     <= bus_c;
            if (LOin)     lo     <= bus_c;
            if (InPC)     pc     <= bus_c;
            if (InPortin) inport <= bus_c;
            if (Yin)      y      <= bus_c;
            if (MDRin)    mdr    <= Read ? Mdatain : bus_c;
            if (ZHighin)  z[2*WIDTH-1:WIDTH] <= alu_c[2*WIDTH-1:WIDTH];
            if (Zlowin)   z[WIDTH-1:0]       <= alu_c[WIDTH-1:0];
        end
    end

    assign BusOut            = bus_c;
    assign mdrData           = mdr;
    assign BusMuxInR0        = gpr[0];
    assign BusMuxInR1        = gpr[1];
    assign BusMuxInR2        = gpr[2];
    assign BusMuxInR3        = gpr[3];
    assign BusMuxInR4        = gpr[4];
    assign BusMuxInR5        = gpr[5];
    assign BusMuxInR6        = gpr[6];
    assign BusMuxInR7        = gpr[7];
    assign BusMuxInR8        = gpr[8];
    assign BusMuxInR9        = gpr[9];
    assign BusMuxInR10       = gpr[10];
    assign BusMuxInR11       = gpr[11];
    assign BusMuxInR12       = gpr[12];
    assign BusMuxInR13       = gpr[13];
    assign BusMuxInR14       = gpr[14];
    assign BusMuxInR15       = gpr[15];
    assign BusMuxInZhigh     = z[2*WIDTH-1:WIDTH];
    assign BusMuxInZlow      = z[WIDTH-1:0];
    assign BusMuxInPCout     = pc;
    assign BusMuxInInPortout = inport;
    assign BusMuxInYout      = y;
    assign BusMuxInHI        = hi;
    assign BusMuxInLO        = lo;

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues expected values, a negedge monitor compares them.
module tb_data_path;

    localparam int IHI = 16, ILO = 17, IZH = 18, IZL = 19, IPC = 20, IMDR = 21, IINP = 22, IY = 23, IBUS = 24;

    logic        Clock = 1'b0;
    logic        clear;
    logic        Read;
    logic [4:0]  op;
    logic [31:0] Mdatain;
    logic [23:0] outs, ins;

    logic [31:0] BusOut, mdrData, zh, zl, pcv, inpv, yv, hiv, lov;
    logic [31:0] r_obs [16];

    typedef struct {
        int          sig;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  t_op [12];
    logic [31:0] t_lo [12];

    data_path dut (
        .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
        .R0out(outs[0]), .R1out(outs[1]), .R2out(outs[2]), .R3out(outs[3]),
        .R4out(outs[4]), .R5out(outs[5]), .R6out(outs[6]), .R7out(outs[7]),
        .R8out(outs[8]), .R9out(outs[9]), .R10out(outs[10]), .R11out(outs[11]),
        .R12out(outs[12]), .R13out(outs[13]), .R14out(outs[14]), .R15out(outs[15]),
        .HIOut(outs[16]), .LOout(outs[17]), .Zhighout(outs[18]), .Zlowout(outs[19]),
        .PCout(outs[20]), .MDRout(outs[21]), .InPortout(outs[22]), .Yout(outs[23]),
        .R0in(ins[0]), .R1in(ins[1]), .R2in(ins[2]), .R3in(ins[3]),
        .R4in(ins[4]), .R5in(ins[5]), .R6in(ins[6]), .R7in(ins[7]),
        .R8in(ins[8]), .R9in(ins[9]), .R10in(ins[10]), .R11in(ins[11]),
        .R12in(ins[12]), .R13in(ins[13]), .R14in(ins[14]), .R15in(ins[15]),
        .HIin(ins[16]), .LOin(ins[17]), .ZHighin(ins[18]), .Zlowin(ins[19]),
        .InPC(ins[20]), .MDRin(ins[21]), .InPortin(ins[22]), .Yin(ins[23]),
        .BusOut(BusOut), .mdrData(mdrData),
        .BusMuxInR0(r_obs[0]), .BusMuxInR1(r_obs[1]), .BusMuxInR2(r_obs[2]), .BusMuxInR3(r_obs[3]),
        .BusMuxInR4(r_obs[4]), .BusMuxInR5(r_obs[5]), .BusMuxInR6(r_obs[6]), .BusMuxInR7(r_obs[7]),
        .BusMuxInR8(r_obs[8]), .BusMuxInR9(r_obs[9]), .BusMuxInR10(r_obs[10]), .BusMuxInR11(r_obs[11]),
        .BusMuxInR12(r_obs[12]), .BusMuxInR13(r_obs[13]), .BusMuxInR14(r_obs[14]), .BusMuxInR15(r_obs[15]),
        .BusMuxInZhigh(zh), .BusMuxInZlow(zl), .BusMuxInPCout(pcv),
        .BusMuxInInPortout(inpv), .BusMuxInYout(yv), .BusMuxInHI(hiv), .BusMuxInLO(lov)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] obs(input int s);
        if (s < 16) return r_obs[s];
        case (s)
            IHI:     return hiv;
            ILO:     return lov;
            IZH:     return zh;
            IZL:     return zl;
            IPC:     return pcv;
            IMDR:    return mdrData;
            IINP:    return inpv;
            IY:      return yv;
            default: return BusOut;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        if (s < 16) return $sformatf("R%0d", s);
        case (s)
            IHI:     return "HI";
            ILO:     return "LO";
            IZH:     return "Zhigh";
            IZL:     return "Zlow";
            IPC:     return "PC";
            IMDR:    return "MDR";
            IINP:    return "InPort";
            IY:      return "Y";
            default: return "BusOut";
        endcase
    endfunction

    function automatic logic [23:0] bit_m(input int k);
        return 24'(1) << k;
    endfunction

    // Monitor: every queued expectation is compared at the next falling edge
    always @(negedge Clock) begin : monitor
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (obs(e.sig) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h", sig_name(e.sig), obs(e.sig), e.val);
            end
        end
    end

    task automatic push_exp(input int s, input logic [31:0] v);
        sb.push_back('{s, v});
    endtask

    // One clock of strobes; entered and left at posedge+1
    task automatic step(input logic [23:0] o, input logic [23:0] i, input logic [4:0] opc,
                        input logic rd, input logic [31:0] md);
        outs = o; ins = i; op = opc; Read = rd; Mdatain = md;
        @(posedge Clock);
        #1;
        outs = '0; ins = '0; Read = 1'b0;
    endtask

    task automatic peek(input logic [23:0] o, input logic [31:0] v);
        outs = o;
        push_exp(IBUS, v);
        @(posedge Clock);
        #1;
        outs = '0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        step('0, bit_m(IMDR), 5'd0, 1'b1, v);
    endtask

    task automatic set_reg(input int k, input logic [31:0] v);
        load_mdr(v);
        step(bit_m(IMDR), bit_m(k), 5'd0, 1'b0, 32'd0);
    endtask

    task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] opc);
        set_reg(IY, a);
        load_mdr(b);
        step(bit_m(IMDR), bit_m(IZH) | bit_m(IZL), opc, 1'b0, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        t_op = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd31, 5'd0, 5'd1};
        t_lo = '{32'h0000_0000, 32'h8000_0014, 32'h0800_0001, 32'hF800_0001,
                 32'h0000_0100, 32'h0800_0001, 32'h0000_0108, 32'hFFFF_FFFB,
                 32'hFFFF_FFFC, 32'h0000_0004, 32'h8000_0014, 32'h8000_000C};
        clear = 1'b0; Read = 1'b0; op = '0; Mdatain = '0; outs = '0; ins = '0;

        // Power-on reset state
        @(posedge Clock); #1;
        push_exp(0, 32'd0); push_exp(IPC, 32'd0); push_exp(IZL, 32'd0); push_exp(IBUS, 32'd0);
        @(posedge Clock); #1;
        clear = 1'b1;

        // NOT flow
        load_mdr(32'd12);                                   push_exp(IMDR, 32'd12);
        step(bit_m(IMDR), bit_m(7), 5'd0, 1'b0, 32'd0);     push_exp(7, 32'd12);
        step(bit_m(7), bit_m(IY), 5'd0, 1'b0, 32'd0);       push_exp(IY, 32'd12);
        step(bit_m(7), bit_m(IZL), 5'd9, 1'b0, 32'd0);      push_exp(IZL, 32'hFFFF_FFF3);
        step(bit_m(IZL), bit_m(1), 5'd0, 1'b0, 32'd0);      push_exp(1, 32'hFFFF_FFF3);

        // Asynchronous clear in mid-cycle while R3 drives the bus
        set_reg(3, 32'd5);
        set_reg(IPC, 32'd9);
        push_exp(3, 32'd5); push_exp(IPC, 32'd9);
        step('0, '0, 5'd0, 1'b0, 32'd0);
        outs = bit_m(3);
        #2 clear = 1'b0;
        #1;
        push_exp(3, 32'd0); push_exp(IPC, 32'd0); push_exp(1, 32'd0);
        push_exp(IMDR, 32'd0); push_exp(IY, 32'd0); push_exp(IZL, 32'd0); push_exp(IBUS, 32'd0);
        @(posedge Clock); #1;
        clear = 1'b1; outs = '0;

        // ADD wrap and SUB borrow
        alu(32'hFFFF_FFFF, 32'd1, 5'd0); push_exp(IZL, 32'd0); push_exp(IZH, 32'd0);
        alu(32'd3, 32'd5, 5'd1);         push_exp(IZL, 32'hFFFF_FFFE); push_exp(IZH, 32'd0);

        // Logic, shift, rotate, unary and pass-through ops with A=80000010, B=4
        for (int k = 0; k < 12; k++) begin
            alu(32'h8000_0010, 32'd4, t_op[k]);
            push_exp(IZL, t_lo[k]);
            push_exp(IZH, 32'd0);
        end

`ifdef MUL_DIV_EN
        alu(32'hFFFF_FFFD, 32'd7, 5'd11); push_exp(IZH, 32'hFFFF_FFFF); push_exp(IZL, 32'hFFFF_FFEB);
        alu(32'd17, 32'd5, 5'd12);        push_exp(IZL, 32'd3);          push_exp(IZH, 32'd2);
        alu(32'd17, 32'd0, 5'd12);        push_exp(IZL, 32'hFFFF_FFFF); push_exp(IZH, 32'd17);
`else
        alu(32'hFFFF_FFFD, 32'd7, 5'd11); push_exp(IZH, 32'd0); push_exp(IZL, 32'd0);
        alu(32'd17, 32'd5, 5'd4);         push_exp(IZL, 32'd0); push_exp(IZH, 32'd0);
        alu(32'd17, 32'd0, 5'd4);         push_exp(IZL, 32'd17);
        alu(32'd17, 32'd5, 5'd12);        push_exp(IZL, 32'd0); push_exp(IZH, 32'd0);
`endif

        // Bus priority, idle bus, MDR bus capture, multi-target load
        set_reg(2, 32'hAAAA_0000);
        set_reg(5, 32'h0000_5555);
        peek(bit_m(2) | bit_m(5), 32'hAAAA_0000);
        peek('0, 32'd0);
        peek(bit_m(5) | bit_m(IY), 32'h0000_5555);
        peek(bit_m(IZL) | bit_m(IPC) | bit_m(IMDR), zl);
        step(bit_m(2), bit_m(IMDR), 5'd0, 1'b0, 32'hDEAD_BEEF);
        push_exp(IMDR, 32'hAAAA_0000);
        step(bit_m(5), bit_m(8) | bit_m(9) | bit_m(IHI), 5'd0, 1'b0, 32'd0);
        push_exp(8, 32'h0000_5555); push_exp(9, 32'h0000_5555); push_exp(IHI, 32'h0000_5555);
        step(bit_m(2), bit_m(IINP) | bit_m(2) | bit_m(ILO), 5'd0, 1'b0, 32'd0);
        push_exp(IINP, 32'hAAAA_0000); push_exp(2, 32'hAAAA_0000); push_exp(ILO, 32'hAAAA_0000);
        peek(bit_m(IHI) | bit_m(ILO), 32'h0000_5555);
        peek(bit_m(IINP) | bit_m(IY), 32'hAAAA_0000);

        // Drain and confirm every expectation was consumed
        @(posedge Clock); #1;
        @(negedge Clock); #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
